// File: rtl/num2ascii_stream.sv
// rtl/num2ascii_stream.sv - binary to decimal ASCII character stream converter
// Double-dabble conversion, then digits MSB first over a valid/ready handshake.
module num2ascii_stream #(
    parameter int         WIDTH       = 32,
    parameter int         DIGITS      = 10,
    parameter int         LZ_SUPPRESS = 1,
    parameter int         TERM_EN     = 1,
    parameter logic [7:0] TERM_CHAR   = 8'h0A
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             ready_i,
    output logic [7:0]       char_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o
);
    localparam int BCD_D = (WIDTH * 3) / 10 + 1;
    // Extra digits beyond BCD_D (only when DIGITS > BCD_D) always stay zero.
    localparam int NPAD  = (DIGITS > BCD_D) ? DIGITS : BCD_D;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int IW    = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_EMIT, S_TERM} state_t;
    state_t r_state, w_state_nxt;

    logic [WIDTH-1:0]  r_bin;
    logic [4*NPAD-1:0] r_bcd;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic              r_ovf;
    logic              r_done;

    logic [4*NPAD-1:0] w_adj;
    logic [4*NPAD-1:0] w_dab;
    logic              w_unused_carry;
    logic              w_conv_last;
    logic              w_fin;
    logic              w_ovf;
    logic [IW-1:0]     w_nz_idx;
    logic [IW-1:0]     w_first;
    logic [3:0]        w_digit;

    always_comb begin
        w_adj = '0;
        for (int d = 0; d < NPAD; d++) begin
            w_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? r_bcd[4*d +: 4] + 4'd3
                                                         : r_bcd[4*d +: 4];
        end
    end

    assign w_dab          = {w_adj[4*NPAD-2:0], r_bin[WIDTH-1]};
    assign w_unused_carry = w_adj[4*NPAD-1];
    assign w_conv_last    = (r_cnt == CW'(1));

    // Evaluated on the final shifted value so EMIT can start the very next cycle.
    always_comb begin
        w_ovf    = 1'b0;
        w_nz_idx = '0;
        for (int i = 0; i < NPAD; i++) begin
            if (w_dab[4*i +: 4] != 4'd0) begin
                if (i >= DIGITS) w_ovf = 1'b1;
                else             w_nz_idx = IW'(i);
            end
        end
    end

    assign w_first = (w_ovf || LZ_SUPPRESS == 0) ? IW'(DIGITS - 1) : w_nz_idx;

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) w_digit = r_bcd[4*i +: 4];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fin       = 1'b0;
        valid_o     = 1'b0;
        char_o      = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_state_nxt = S_CONVERT;
            end
            S_CONVERT: begin
                if (w_conv_last) w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                valid_o = 1'b1;
                char_o  = r_ovf ? 8'h39 : {4'h3, w_digit};
                if (ready_i && r_idx == '0) begin
                    if (TERM_EN != 0) begin
                        w_state_nxt = S_TERM;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_fin       = 1'b1;
                    end
                end
            end
            S_TERM: begin
                valid_o = 1'b1;
                char_o  = TERM_CHAR;
                if (ready_i) begin
                    w_state_nxt = S_IDLE;
                    w_fin       = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fin;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_bin <= value_i;
                        r_bcd <= '0;
                        r_cnt <= CW'(WIDTH);
                        r_ovf <= 1'b0;
                    end
                end
                S_CONVERT: begin
                    r_bin <= {r_bin[WIDTH-2:0], 1'b0};
                    r_bcd <= w_dab;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_conv_last) begin
                        r_ovf <= w_ovf;
                        r_idx <= w_first;
                    end
                end
                S_EMIT: begin
                    if (ready_i && r_idx != '0) r_idx <= r_idx - IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (r_state != S_IDLE);
    assign done_o = r_done;
    assign ovf_o  = r_ovf;

endmodule
